alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, data path width; the block SHALL accept any even value from 8 to 64.
REQ-002 Parameter SHW, default 5, shift-amount width; the block SHALL require SHW = clog2(WIDTH).
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 data1  input  WIDTH  operand A; signed for SLT and SRA.
REQ-008 data2  input  WIDTH  operand B; signed for SLT.
REQ-009 shamt  input  SHW  shift amount.
REQ-010 alu_ctrl  input  4  opcode.
REQ-011 out_valid  output  1  result held valid.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 alu_res  output  WIDTH  result.
REQ-014 zero  output  1  alu_res == 0, valid with out_valid.
REQ-015 illegal  output  1  the opcode of the held result was undefined.
REQ-016 busy  output  1  a multi-cycle operation is in progress.

Function
REQ-017 Opcodes: ADD 0001, SUB 0010, AND 0100, OR 0101, XOR 0110, LUI 0111, SLT 1010, SLTU 1011, SLL 0000, SRL 1111, SRA 1110, MUL 1000, DIVU 1100, REMU 1101; the encodings 0011 and 1001 SHALL be illegal.
REQ-018 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-019 LUI SHALL produce {data2[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-020 SLT (signed) and SLTU (unsigned) SHALL produce 1 if data1 < data2, else 0.
REQ-021 SLL and SRL SHALL zero-fill, SRA SHALL sign-fill, and all shifts SHALL shift data1 by shamt.
REQ-022 MUL SHALL produce the low WIDTH bits of data1*data2, computed iteratively as shift-add at one bit per cycle.
REQ-023 DIVU/REMU SHALL produce the unsigned quotient/remainder of data1/data2, computed by restoring division at one bit per cycle.
REQ-024 Divide by zero SHALL give DIVU = all ones and REMU = data1, after the full latency and with illegal=0.
REQ-025 The FSM SHALL have three states: IDLE, BUSY and DONE; in_ready=1 only in IDLE.
REQ-026 IDLE, on in_valid=1: the block SHALL capture the operands and opcode; a single-cycle op or illegal op SHALL go to DONE, and MUL/DIVU/REMU SHALL go to BUSY with the iteration counter loaded to WIDTH.
REQ-027 BUSY: the counter SHALL decrement once per cycle, and the FSM SHALL go to DONE on the cycle the counter reaches 0; busy=1 only in BUSY.
REQ-028 Latency from the accepting edge to out_valid SHALL be 1 cycle for single-cycle ops and WIDTH+1 cycles for MUL/DIVU/REMU.
REQ-029 DONE: out_valid=1, and alu_res, zero and illegal SHALL hold stable until out_ready=1.
REQ-030 DONE with out_ready=1 SHALL return the FSM to IDLE on the next edge; back-to-back throughput is therefore one op per 2 cycles at best.
REQ-031 An illegal opcode SHALL give alu_res=0, zero=1 and illegal=1 with 1-cycle latency.
REQ-032 in_valid while in_ready=0 SHALL be ignored, with no side effects on operands or state.
REQ-033 Input changes after acceptance SHALL NOT affect the result in flight.
REQ-034 out_ready outside DONE SHALL be ignored.

Reset
REQ-035 On rst_n=0 the block SHALL immediately force: state IDLE, counter 0, alu_res 0, zero 0, illegal 0, out_valid 0, busy 0 and in_ready 0.
REQ-036 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-037 Reset during BUSY or DONE SHALL abort the operation and discard the result; no out_valid SHALL appear for it.

Verification (WIDTH=32)
REQ-038 ADD 0x7FFFFFFF+1 -> out_valid 1 cycle after accept, alu_res=0x80000000, zero=0; SUB 5-5 -> alu_res=0, zero=1.
REQ-039 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000.
REQ-040 MUL 0x10000 * 0x10001 -> alu_res=0x00010000 with out_valid exactly 33 cycles after accept and busy=1 for 32 cycles; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-041 DIVU 123/0 -> 0xFFFFFFFF; REMU 123/0 -> 123; illegal=0 in both cases.
REQ-042 Hold out_ready=0 for 10 cycles in DONE -> out_valid and alu_res stable and in_ready=0 throughout; pulse in_valid during BUSY -> ignored.
REQ-043 Assert rst_n=0 mid-MUL -> all outputs 0 without waiting for a clock; a subsequent ADD 2+3 -> 5 after 1 cycle; opcode 0011 -> illegal=1, alu_res=0.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add
// multiply and restoring divide, all behind a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for an operation, in_ready=1
//   BUSY  | one multiply/divide iteration per cycle
//   DONE  | result held until out_ready
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_LUI  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;
  localparam logic [3:0] OP_SRL  = 4'b1111;

  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             started;
  logic [SHW:0]     cnt;
  logic             op_div, op_rem;
  logic [WIDTH-1:0] acc, opa, opb;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, illegal_q;

  logic [WIDTH-1:0] sc_res;
  logic             sc_illegal, sc_multi;
  logic [WIDTH:0]   shifted, diff;
  logic             neg;
  logic [WIDTH-1:0] mul_acc, rem_nxt, quo_nxt, fin_res;
  logic             accept;

  assign in_ready  = (state == IDLE) && started;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign accept    = in_ready && in_valid;
  assign alu_res   = res_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    sc_res     = '0;
    sc_illegal = 1'b0;
    sc_multi   = 1'b0;
    case (alu_ctrl)
      OP_ADD:  sc_res = data1 + data2;
      OP_SUB:  sc_res = data1 - data2;
      OP_AND:  sc_res = data1 & data2;
      OP_OR:   sc_res = data1 | data2;
      OP_XOR:  sc_res = data1 ^ data2;
      OP_LUI:  sc_res = {data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, data1 < data2};
      OP_SLL:  sc_res = data1 << shamt;
      OP_SRL:  sc_res = data1 >> shamt;
      OP_SRA:  sc_res = $signed(data1) >>> shamt;
      OP_MUL, OP_DIVU, OP_REMU: sc_multi = 1'b1;
      default: sc_illegal = 1'b1;
    endcase
  end

  // acc is the product/remainder, opa the multiplier/quotient, opb the
  // multiplicand/divisor; a zero divisor naturally yields all-ones / data1.
  always_comb begin
    mul_acc = acc + (opa[0] ? opb : '0);
    shifted = {acc, opa[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
    neg     = diff[WIDTH];
    rem_nxt = neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {opa[WIDTH-2:0], ~neg};
    fin_res = op_div ? (op_rem ? rem_nxt : quo_nxt) : mul_acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sc_multi ? BUSY : DONE;
      BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      cnt       <= '0;
      op_div    <= 1'b0;
      op_rem    <= 1'b0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        op_div <= alu_ctrl[2];
        op_rem <= alu_ctrl[0];
        acc    <= '0;
        opa    <= data1;
        opb    <= data2;
        if (sc_multi) begin
          cnt <= CNT_LOAD;
        end else begin
          res_q     <= sc_res;
          zero_q    <= (sc_res == '0);
          illegal_q <= sc_illegal;
        end
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_LAST;
        if (op_div) begin
          acc <= rem_nxt;
          opa <= quo_nxt;
        end else begin
          acc <= mul_acc;
          opa <= opa >> 1;
          opb <= opb << 1;
        end
        if (cnt == CNT_LAST) begin
          res_q     <= fin_res;
          zero_q    <= (fin_res == '0);
          illegal_q <= 1'b0;
        end
      end
    end
  end

endmodule
